// File: rtl/uart_rx_reader.sv
// UART 8N1 receiver: 2-flop synchronized line, centre-of-bit sampling,
// single-entry valid/ready output register with frame-error and overrun pulses.
module uart_rx_reader #(
    parameter int unsigned clk_mhz  = 50,
    parameter int unsigned boadrate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       down_valid,
    input  logic       down_ready,
    output logic [7:0] down_data,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int unsigned SCALE = clk_mhz * 1000 * 1000 / boadrate;
    localparam int unsigned HALF  = SCALE / 2;
    localparam int unsigned CW    = $clog2(SCALE);
    localparam logic [CW-1:0] SCALE_M1 = CW'(SCALE - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_d;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            down_valid <= 1'b0;
            down_data  <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_d      <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A delivery later in this block overrides this clear.
            if (down_valid && down_ready)
                down_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        cnt   <= HALF_M1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            cnt     <= SCALE_M1;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift_reg[bit_idx] <= rx_s;
                        cnt                <= SCALE_M1;
                        bit_idx            <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (!down_valid || down_ready) begin
                            down_data  <= shift_reg;
                            down_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx_reader.md
Name: uart_rx_reader

Overview:
UART 8N1 receiver. It is the receive-side counterpart of the team's uart_tx_writer.
- Samples the asynchronous serial line rx and reassembles bytes LSB-first.
- Presents each byte on a single-entry valid/ready output register. The downstream is a custom_fifo_valid_ready or any valid/ready consumer.
- Reports framing errors and overruns as one-cycle pulses.

Parameters:
clk_mhz, 50, system clock frequency in MHz
boadrate, 9600, line bit rate in baud; SCALE = clk_mhz*1000*1000/boadrate clocks per bit, HALF = SCALE/2 (integer division, SCALE >= 4 required)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
rx  input  1  serial line, idle high, asynchronous to clk
down_valid  output  1  output register holds an unread byte
down_ready  input  1  consumer accepts byte when down_valid & down_ready
down_data  output  8  received byte, stable while down_valid=1
busy  output  1  high in any state other than IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
overrun  output  1  one-cycle pulse: byte completed while output register full and not being drained, new byte discarded

Behaviour:
- Reset values, applied on a clk edge with rst=1: down_valid=0, down_data=0, frame_err=0, overrun=0, busy=0. State goes to IDLE, counters go to 0, both synchronizer flops go to 1. Reset mid-frame abandons the frame with no pulses.
- Input path: rx passes through a 2-flop synchronizer (rx_s). A third flop (rx_d) holds the previous rx_s for edge detection.
- States and transitions:
  - IDLE: on rx_d=1 & rx_s=0 (falling edge), load cnt=HALF-1 and go to START. A line held low (break) produces no edge and therefore no start.
  - START: decrement cnt. At cnt==0, if rx_s=0, load cnt=SCALE-1, bit_idx=0 and go to DATA. If rx_s=1, treat it as a glitch and return to IDLE with no pulse.
  - DATA: decrement cnt. At cnt==0, shift rx_s into shift_reg[bit_idx] (LSB first), reload cnt=SCALE-1 and increment bit_idx. After bit_idx 7 is sampled, go to STOP with cnt=SCALE-1.
  - STOP: decrement cnt. At cnt==0, sample rx_s and go to IDLE.
    - Stop bit = 1: deliver shift_reg.
    - Stop bit = 0: assert frame_err on the next cycle and do not deliver.
- Sampling: every sample is taken at the nominal bit centre, at HALF + k*SCALE clocks after the synchronized falling edge. A new start edge can be detected from the cycle after the STOP sample, so back-to-back frames with a single stop bit are supported.
- Delivery, evaluated on the cycle of the STOP sample:
  - down_valid=0: load down_data; down_valid=1 on the next cycle.
  - down_valid=1 & down_ready=1: load the new byte; down_valid stays 1.
  - down_valid=1 & down_ready=0: keep the old byte, pulse overrun for one cycle, drop the new byte.
- Output handshake: down_valid clears on a down_valid & down_ready cycle unless a delivery coincides. down_data never changes while down_valid=1 & down_ready=0.
- Latency: the line falling edge reaches rx_s 2 clocks later. down_valid rises 1 clock after the STOP-sample clock.
- Pulse timing: frame_err and overrun each last exactly one clock, and they are never both asserted for the same frame.

Test Plan:
1. clk_mhz=1, boadrate=100000 (SCALE=10, HALF=5), down_ready=1, send 0xA5 with 1 stop bit -> down_valid high for 1 cycle with down_data=0xA5; frame_err=0; busy high for the frame, then low.
2. rx low for 3 clocks then high (glitch shorter than HALF) -> returns to IDLE, no down_valid, no frame_err; a following 0x5A frame is received correctly.
3. Send 0x3C with the stop bit driven 0 -> frame_err pulses 1 cycle, down_valid stays 0. Line then held low for 30 clocks -> no new start. Return high, send 0x81 -> 0x81 received.
4. down_ready=0, send 0x11 then 0x22 -> down_data=0x11 held; overrun pulses once at the 0x22 stop; on down_ready=1, 0x11 is consumed and down_valid drops.
5. down_ready=1, back-to-back 0x00 and 0xFF with no idle gap after the stop bit -> two valid beats, data 0x00 then 0xFF, no errors.
6. Assert rst during data bit 4 of a frame -> all outputs 0 on the next edge. Release rst with the line idle, send 0xC3 -> 0xC3 received.
